// File: rtl/regfile_dump_pkg.sv
// Shared widths and state encoding for the register-file dump reader.
package regfile_dump_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned NUM_REGS       = 2 ** DEFAULT_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) register range through a combinational read
// port and streams each (address, data) pair out over valid/ready.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_addr,
    input  logic [ADDR_W-1:0]   last_addr,
    input  logic                abort,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     beat_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    dump_state_t        state;
    dump_state_t        state_nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  end_addr;
    logic               accept;
    logic               hs;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; abort beats a same-cycle handshake, start is only seen in IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    hs        = 1'b1;
                    state_nxt = out_last ? IDLE : READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; rd_addr tracks ptr whenever busy
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            end_addr   <= '0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_count <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);

            if (accept) begin
                ptr        <= first_addr;
                end_addr   <= last_addr;
                rd_addr    <= first_addr;
                beat_count <= '0;
            end

            if (state == READ && !abort) begin
                out_data  <= rd_data;
                out_addr  <= ptr;
                out_last  <= (ptr == end_addr);
                out_valid <= 1'b1;
            end

            if (state != IDLE && abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_addr   <= '0;
            end

            if (hs) begin
                out_valid  <= 1'b0;
                beat_count <= beat_count + CNT_W'(1);
                if (out_last) begin
                    done     <= 1'b1;
                    out_last <= 1'b0;
                    rd_addr  <= '0;
                end else begin
                    ptr     <= ptr + ADDR_W'(1);
                    rd_addr <= ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Table-driven and randomized checks of the dump reader against an address-list model.
module tb_regfile_dump_reader;
    import regfile_dump_pkg::*;

    localparam int unsigned AW = DEFAULT_ADDR_W;
    localparam int unsigned DW = DEFAULT_DATA_W;
    localparam int NR = NUM_REGS;

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [AW-1:0] first_addr, last_addr, rd_addr, out_addr;
    logic [DW-1:0] rd_data, out_data;
    logic          out_valid, out_last, busy, done;
    logic [AW:0]   beat_count;

    logic [DW-1:0] mem [NR];
    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .beat_count(beat_count)
    );

    typedef struct {
        int first;
        int last;
        int stall_addr;
        int stall_cyc;
        int abort_after;
        int restart_at;
        int reset_at;
        bit rnd;
        bit abort_on_start;
        int exp_count;
        int exp_done;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int f, input int l, input int sa, input int sc,
                                input int ab, input int rs, input int rt, input bit rnd,
                                input bit aos, input int ec, input int ed);
        vec_t v;
        v.first = f; v.last = l; v.stall_addr = sa; v.stall_cyc = sc;
        v.abort_after = ab; v.restart_at = rs; v.reset_at = rt; v.rnd = rnd;
        v.abort_on_start = aos; v.exp_count = ec; v.exp_done = ed;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_addr"}, 64'(out_addr), 0);
        chk({tag, "_out_data"}, 64'(out_data), 0);
        chk({tag, "_out_last"}, 64'(out_last), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_beat_count"}, 64'(beat_count), 0);
    endtask

    // Model: beat k carries address (first+k) mod NR; the dump has ((last-first) mod NR)+1 beats.
    task automatic run_dump(input vec_t v, input string tag);
        int n, k, cyc, stalls, done_cnt;
        bit fin, aborting, resetting, restarted;
        logic [AW-1:0] ea;
        n = ((v.last - v.first + NR) % NR) + 1;
        k = 0; cyc = 0; stalls = 0; done_cnt = 0;
        fin = 0; aborting = 0; resetting = 0; restarted = 0;
        ea = AW'(v.first);

        @(negedge clk);
        start = 1'b1; abort = v.abort_on_start; out_ready = 1'b0;
        first_addr = AW'(v.first); last_addr = AW'(v.last);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        first_addr = AW'($urandom); last_addr = AW'($urandom);
        chk({tag, "_busy_after_start"}, 64'(busy), 1);
        chk({tag, "_valid_read_cycle"}, 64'(out_valid), 0);
        chk({tag, "_rd_addr_first"}, 64'(rd_addr), 64'(v.first));

        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0; reset = 1'b0;
            if (aborting) begin
                chk({tag, "_abort_valid"}, 64'(out_valid), 0);
                chk({tag, "_abort_busy"}, 64'(busy), 0);
                chk({tag, "_abort_count"}, 64'(beat_count), 64'(v.exp_count));
                chk({tag, "_abort_last"}, 64'(out_last), 0);
                chk({tag, "_abort_stale_addr"}, 64'(out_addr), 64'(ea));
                if (done) done_cnt++;
                @(negedge clk);
                if (done) done_cnt++;
                fin = 1;
            end else if (resetting) begin
                check_reset_outputs({tag, "_midreset"});
                fin = 1;
            end else if (done) begin
                done_cnt++;
                chk({tag, "_beats_seen"}, 64'(k), 64'(n));
                chk({tag, "_end_busy"}, 64'(busy), 0);
                chk({tag, "_end_count"}, 64'(beat_count), 64'(v.exp_count));
                chk({tag, "_end_valid"}, 64'(out_valid), 0);
                chk({tag, "_end_last"}, 64'(out_last), 0);
                chk({tag, "_end_rd_addr"}, 64'(rd_addr), 0);
                if (!v.rnd && v.stall_cyc == 0)
                    chk({tag, "_cycles"}, 64'(cyc), 64'(2 * n));
                @(negedge clk);
                chk({tag, "_done_one_cycle"}, 64'(done), 0);
                fin = 1;
            end else if (out_valid) begin
                ea = AW'((v.first + k) % NR);
                chk({tag, "_addr"}, 64'(out_addr), 64'(ea));
                chk({tag, "_data"}, 64'(out_data), 64'(mem[ea]));
                chk({tag, "_last"}, 64'(out_last), 64'(k == n - 1));
                chk({tag, "_rd_addr_send"}, 64'(rd_addr), 64'(ea));
                chk({tag, "_count_live"}, 64'(beat_count), 64'(k));
                if (k == v.reset_at) begin
                    reset = 1'b1; resetting = 1;
                end else if (k == v.abort_after) begin
                    abort = 1'b1; out_ready = 1'b1; aborting = 1;
                end else begin
                    if (int'(ea) == v.stall_addr && stalls < v.stall_cyc) begin
                        out_ready = 1'b0; stalls++;
                    end else begin
                        out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (int'(ea) == v.restart_at && !restarted) begin
                        start = 1'b1; first_addr = AW'(10); restarted = 1;
                    end
                    if (out_ready) k++;
                end
            end else begin
                out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                chk({tag, "_busy_read"}, 64'(busy), 1);
                if (k < n) chk({tag, "_rd_addr_read"}, 64'(rd_addr), 64'((v.first + k) % NR));
            end
            if (cyc > 2000) begin
                chk({tag, "_timeout"}, 0, 1);
                fin = 1;
            end
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(v.exp_done));
    endtask

    vec_t vecs[8];

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < NR; i++) mem[i] = DW'(i * 4);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        vecs[0] = mk(0, 31, -1, 0, -1, -1, -1, 0, 0, 32, 1);  // full
        vecs[1] = mk(0, 31,  5, 3, -1, -1, -1, 0, 0, 32, 1);  // backpressure at addr 5
        vecs[2] = mk(30, 1, -1, 0, -1, -1, -1, 0, 0, 4, 1);   // wrap
        vecs[3] = mk(7, 7,  -1, 0, -1, -1, -1, 0, 0, 1, 1);   // single
        vecs[4] = mk(0, 31, -1, 0,  3, -1, -1, 0, 0, 3, 0);   // abort after 3rd beat
        vecs[5] = mk(0, 31, -1, 0, -1,  4, -1, 0, 0, 32, 1);  // start ignored while busy
        vecs[6] = mk(0, 31, -1, 0, -1, -1,  8, 0, 0, 0, 0);   // reset mid-dump
        vecs[7] = mk(2, 5,  -1, 0, -1, -1, -1, 0, 1, 4, 1);   // start+abort in IDLE

        for (int i = 0; i < 8; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 12; r++) begin
            vec_t v;
            int f, l, n, ab;
            for (int i = 0; i < NR; i++) mem[i] = $urandom;
            f = int'($urandom_range(0, NR - 1));
            l = int'($urandom_range(0, NR - 1));
            n = ((l - f + NR) % NR) + 1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            v = mk(f, l, -1, 0, ab, -1, -1, 1, 0, (ab >= 0) ? ab : n, (ab >= 0) ? 0 : 1);
            run_dump(v, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
